// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline stage register.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int OCC_W = 2;

  // Stage fill state; encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Number of entries held in a given state.
  function automatic logic [OCC_W-1:0] occ_of(input state_t s);
    case (s)
      HALF:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_data_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_data_reg
// Description : WIDTH-bit payload register with write enable and
//               asynchronous active-low reset to RESET_VALUE.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_data_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Capture the payload when enabled; reset forces the known value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= RESET_VALUE;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready pipeline stage register with synchronous flush
//               and optional two-entry skid buffer (registered in_ready).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SKID        = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_out_valid;
  logic [OCC_W-1:0] r_occ;

  logic             w_accept;
  logic             w_issue;
  logic             w_main_we;
  logic             w_main_from_skid;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_accept = in_valid && in_ready;
  assign w_issue  = r_out_valid && out_ready;

  // Next-state and main-register write decode; flush wins over everything
  // and leaves the data registers untouched.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_we        = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt = HALF;
          w_main_we   = 1'b1;
        end
      end
      HALF: begin
        if (w_accept && w_issue) begin
          w_main_we = 1'b1;
        end else if (w_accept) begin
          // Only reachable with the skid buffer: downstream stalled, park
          // the new payload behind the one in main.
          w_state_nxt = FULL;
        end else if (w_issue) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_issue) begin
          w_state_nxt      = HALF;
          w_main_we        = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
    if (flush) begin
      w_state_nxt      = EMPTY;
      w_main_we        = 1'b0;
      w_main_from_skid = 1'b0;
    end
  end

  // Control state with registered valid and occupancy outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_occ       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != EMPTY);
      r_occ       <= occ_of(w_state_nxt);
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

  pipe_data_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main_reg (
    .clk  (clk),
    .rst  (rst),
    .i_we (w_main_we),
    .i_d  (w_main_d),
    .o_q  (w_main_q)
  );

  if (SKID) begin : g_skid
    logic w_skid_we;

    // The skid entry is written only on the HALF -> FULL transition.
    assign w_skid_we = (r_state == HALF) && (w_state_nxt == FULL);

    pipe_data_reg #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_skid_reg (
      .clk  (clk),
      .rst  (rst),
      .i_we (w_skid_we),
      .i_d  (in_data),
      .o_q  (w_skid_q)
    );

    // Ready depends only on registered state: no combinational path from
    // out_ready back upstream.
    assign in_ready = (r_state != FULL);
  end else begin : g_noskid
    assign w_skid_q = RESET_VALUE;
    assign in_ready = !r_out_valid || out_ready;
  end

  assign out_valid = r_out_valid;
  assign out_data  = w_main_q;
  assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg, SKID=1 and SKID=0
//               instances checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int          W  = 16;
  localparam logic [15:0] RV = 16'h1234;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  logic          v1 = 1'b0, r1 = 1'b1;
  logic [W-1:0]  d1 = '0;
  logic          rdy1, vld1;
  logic [W-1:0]  q_data1;
  logic [1:0]    occ1;

  logic          v0 = 1'b0, r0 = 1'b1;
  logic [W-1:0]  d0 = '0;
  logic          rdy0, vld0;
  logic [W-1:0]  q_data0;
  logic [1:0]    occ0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m1[$];
  logic [W-1:0] m0[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .out_valid(vld1), .out_ready(r1), .out_data(q_data1),
    .occupancy(occ1)
  );

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(v0), .in_ready(rdy0), .in_data(d0),
    .out_valid(vld0), .out_ready(r0), .out_data(q_data0),
    .occupancy(occ0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each stage is a FIFO of capacity 2 (skid) or 1.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m1.delete();
      m0.delete();
    end else begin
      bit acc, iss;
      acc = v1 && (m1.size() < 2);
      iss = (m1.size() > 0) && r1;
      if (flush) m1.delete();
      else begin
        if (iss) void'(m1.pop_front());
        if (acc) m1.push_back(d1);
      end
      acc = v0 && ((m0.size() == 0) || r0);
      iss = (m0.size() > 0) && r0;
      if (flush) m0.delete();
      else begin
        if (iss) void'(m0.pop_front());
        if (acc) m0.push_back(d0);
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("rdy1", {31'b0, rdy1}, {31'b0, m1.size() < 2});
    chk("vld1", {31'b0, vld1}, {31'b0, m1.size() > 0});
    chk("occ1", {30'b0, occ1}, m1.size());
    if (m1.size() > 0) chk("data1", {16'b0, q_data1}, {16'b0, m1[0]});
    chk("rdy0", {31'b0, rdy0}, {31'b0, (m0.size() == 0) || r0});
    chk("vld0", {31'b0, vld0}, {31'b0, m0.size() > 0});
    chk("occ0", {30'b0, occ0}, m0.size());
    if (m0.size() > 0) chk("data0", {16'b0, q_data0}, {16'b0, m0[0]});
  end

  initial begin
    // Reset held with a pending payload
    v1 = 1'b1; d1 = 16'hDEAD; r1 = 1'b1;
    #12;
    chk("rst_vld",  {31'b0, vld1}, 32'd0);
    chk("rst_rdy",  {31'b0, rdy1}, 32'd1);
    chk("rst_occ",  {30'b0, occ1}, 32'd0);
    chk("rst_data", {16'b0, q_data1}, 32'h1234);
    chk("rst_data0", {16'b0, q_data0}, 32'h1234);
    rst = 1'b1;
    @(negedge clk);
    chk("first_acc_vld", {31'b0, vld1}, 32'd1);
    chk("first_acc_data", {16'b0, q_data1}, 32'hDEAD);
    #1;

    // Streaming 1..4 with out_ready held high
    for (int i = 1; i <= 4; i++) begin
      v1 = 1'b1; d1 = 16'(i);
      @(negedge clk);
      chk("stream_data", {16'b0, q_data1}, i);
      chk("stream_occ", {30'b0, occ1}, 32'd1);
      #1;
    end
    v1 = 1'b0;
    @(negedge clk); #1;

    // Backpressure fills the skid entry
    r1 = 1'b0; v1 = 1'b1; d1 = 16'h000A;
    @(negedge clk);
    chk("bp_half_rdy", {31'b0, rdy1}, 32'd1);
    #1 d1 = 16'h000B;
    @(negedge clk);
    chk("bp_full_occ", {30'b0, occ1}, 32'd2);
    chk("bp_full_rdy", {31'b0, rdy1}, 32'd0);
    chk("bp_full_data", {16'b0, q_data1}, 32'h000A);
    #1 v1 = 1'b0;
    @(negedge clk);
    chk("bp_hold_data", {16'b0, q_data1}, 32'h000A);
    #1 r1 = 1'b1;
    @(negedge clk);
    chk("bp_drain_data", {16'b0, q_data1}, 32'h000B);
    chk("bp_drain_rdy", {31'b0, rdy1}, 32'd1);
    #1;
    @(negedge clk);
    chk("bp_empty_vld", {31'b0, vld1}, 32'd0);
    #1;

    // Flush from FULL with a concurrent input
    r1 = 1'b0; v1 = 1'b1; d1 = 16'h0011;
    @(negedge clk); #1 d1 = 16'h0022;
    @(negedge clk); #1;
    flush = 1'b1; d1 = 16'h0033;
    @(negedge clk);
    chk("flush_vld", {31'b0, vld1}, 32'd0);
    chk("flush_occ", {30'b0, occ1}, 32'd0);
    #1 flush = 1'b0; v1 = 1'b0; r1 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("flush_after_vld", {31'b0, vld1}, 32'd0);
    end
    #1;

    // SKID=0: combinational ready and simultaneous issue/accept
    r0 = 1'b0; v0 = 1'b1; d0 = 16'h0055;
    @(negedge clk);
    chk("s0_full_rdy", {31'b0, rdy0}, 32'd0);
    chk("s0_full_data", {16'b0, q_data0}, 32'h0055);
    #1 d0 = 16'h0066; r0 = 1'b1;
    #1 chk("s0_comb_rdy", {31'b0, rdy0}, 32'd1);
    @(negedge clk);
    chk("s0_pass_data", {16'b0, q_data0}, 32'h0066);
    chk("s0_pass_occ", {30'b0, occ0}, 32'd1);
    #1 v0 = 1'b0;

    // Asynchronous reset while FULL
    r1 = 1'b0; v1 = 1'b1; d1 = 16'h0077;
    @(negedge clk); #1 d1 = 16'h0088;
    @(negedge clk);
    chk("ar_pre_occ", {30'b0, occ1}, 32'd2);
    #1 v1 = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("ar_vld", {31'b0, vld1}, 32'd0);
    chk("ar_occ", {30'b0, occ1}, 32'd0);
    chk("ar_rdy", {31'b0, rdy1}, 32'd1);
    chk("ar_data", {16'b0, q_data1}, 32'h1234);
    @(negedge clk); #1 rst = 1'b1;

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      v1    = ($urandom_range(0, 3) != 0);
      d1    = 16'($urandom);
      r1    = ($urandom_range(0, 2) != 0);
      v0    = ($urandom_range(0, 3) != 0);
      d0    = 16'($urandom);
      r0    = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      @(negedge clk); #1;
    end
    flush = 1'b0; v1 = 1'b0; v0 = 1'b0;
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
